// File: rtl/sau_mau_ping_core.sv
// -----------------------------------------------------------------------------
// sau_mau_ping_core
//
// Boot-ping block. After reset it reads BOOT_BYTES bytes from a serial flash
// at BOOT_ADDR using the single-bit READ (8'h03) command in SPI mode 0. It
// sums the bytes modulo 256, sends that sum once over a UART as one 8N1 frame,
// and then parks in DONE. On entry to DONE, success goes high if and only if
// the sum equals EXPECTED_SUM.
//
// Parameters
//   SCK_DIV      system clocks per SCK half-period (>= 1)
//   UART_DIV     system clocks per UART bit (>= 2)
//   BOOT_ADDR    24-bit flash start address
//   BOOT_BYTES   number of bytes read (1..255)
//   EXPECTED_SUM required 8-bit checksum
//
// Ports
//   clk          system clock, rising edge
//   rstn         asynchronous reset, ACTIVE-HIGH despite the name
//   success      registered pass flag
//   uart_tx      UART transmit line, idles 1
//   uart_rx      UART receive line, unused in this revision
//   qspi_cs      flash chip select, active-low
//   qspi_sck     flash serial clock, idles 0
//   qspi_dq_0    flash SI (MOSI)
//   qspi_dq_1    flash SO (MISO)
//   qspi_dq_2/3  WP#/HOLD#, tied high
//   dbg_state_o  current FSM state:
//                IDLE=0, CMD=1, ADDR=2, DATA=3, CSHOLD=4, UART=5, DONE=6
//
// All outputs come straight from flops, so they are glitch-free. Reset clears
// these flops asynchronously, so the outputs go to their idle levels in the
// same cycle that reset is asserted.
// -----------------------------------------------------------------------------
module sau_mau_ping_core #(
    parameter int unsigned SCK_DIV      = 2,
    parameter int unsigned UART_DIV     = 16,
    parameter logic [23:0] BOOT_ADDR    = 24'h000000,
    parameter int unsigned BOOT_BYTES   = 16,
    parameter logic [7:0]  EXPECTED_SUM = 8'h00
) (
    input  logic       clk,
    input  logic       rstn,
    output logic       success,
    output logic       uart_tx,
    input  logic       uart_rx,
    output logic       qspi_cs,
    output logic       qspi_sck,
    output logic       qspi_dq_0,
    input  logic       qspi_dq_1,
    output logic       qspi_dq_2,
    output logic       qspi_dq_3,
    output logic [2:0] dbg_state_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSHOLD = 3'd4,
        ST_UART   = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    localparam logic [15:0] SCK_LAST  = 16'(SCK_DIV - 1);
    localparam logic [15:0] UART_LAST = 16'(UART_DIV - 1);
    localparam logic [7:0]  BYTE_LAST = 8'(BOOT_BYTES - 1);
    localparam logic [31:0] CMD_ADDR  = {8'h03, BOOT_ADDR};

    state_t      state_q;
    logic [15:0] sck_div_q;   // clocks elapsed in the current SCK half-period
    logic [4:0]  bit_cnt_q;   // bit index within the CMD/ADDR field or the data byte
    logic [7:0]  byte_cnt_q;  // index of the data byte being received
    logic [30:0] tx_sr_q;     // command/address bits not yet placed on dq_0
    logic [6:0]  rx_sr_q;     // bits received so far in the current byte
    logic [7:0]  sum_q;
    logic [15:0] uart_div_q;
    logic [3:0]  uart_bit_q;  // 0 = start bit, 1..8 = data bits, 9 = stop bit
    logic [8:0]  uart_sr_q;   // remaining data bits plus the stop bit
    logic        cs_q;
    logic        sck_q;
    logic        dq0_q;
    logic        tx_q;
    logic        success_q;

    logic        bit_tick;
    logic        sck_rise;
    logic        sck_fall;
    logic        miso_bit;
    logic [7:0]  rx_next;
    logic        unused_uart_rx;

    assign unused_uart_rx = uart_rx;

    // A plain if() treats X or Z on qspi_dq_1 as 0. A ternary on an X select
    // would propagate X into the checksum.
    always_comb begin
        miso_bit = 1'b0;
        if (qspi_dq_1) begin
            miso_bit = 1'b1;
        end
    end

    assign rx_next  = {rx_sr_q, miso_bit};
    assign bit_tick = (sck_div_q == SCK_LAST);
    assign sck_rise = bit_tick && !sck_q;
    assign sck_fall = bit_tick && sck_q;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q    <= ST_IDLE;
            sck_div_q  <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            sum_q      <= '0;
            uart_div_q <= '0;
            uart_bit_q <= '0;
            uart_sr_q  <= '1;
            cs_q       <= 1'b1;
            sck_q      <= 1'b0;
            dq0_q      <= 1'b0;
            tx_q       <= 1'b1;
            success_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Drive the first command bit now. That gives it a full low
                    // half-period of setup time before the first rising SCK edge.
                    cs_q       <= 1'b0;
                    sck_q      <= 1'b0;
                    dq0_q      <= CMD_ADDR[31];
                    tx_sr_q    <= CMD_ADDR[30:0];
                    sck_div_q  <= '0;
                    bit_cnt_q  <= '0;
                    byte_cnt_q <= '0;
                    sum_q      <= '0;
                    state_q    <= ST_CMD;
                end

                ST_CMD, ST_ADDR, ST_DATA: begin
                    if (bit_tick) begin
                        sck_div_q <= '0;
                    end else begin
                        sck_div_q <= sck_div_q + 16'd1;
                    end

                    if (sck_rise) begin
                        sck_q <= 1'b1;
                        if (state_q == ST_DATA) begin
                            rx_sr_q <= rx_next[6:0];
                            if (bit_cnt_q == 5'd7) begin
                                sum_q <= sum_q + rx_next;
                            end
                        end
                    end else if (sck_fall) begin
                        // dq_0 only changes on the edge where SCK goes low.
                        sck_q     <= 1'b0;
                        dq0_q     <= tx_sr_q[30];
                        tx_sr_q   <= {tx_sr_q[29:0], 1'b0};
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                        case (state_q)
                            ST_CMD: begin
                                if (bit_cnt_q == 5'd7) begin
                                    bit_cnt_q <= '0;
                                    state_q   <= ST_ADDR;
                                end
                            end
                            ST_ADDR: begin
                                if (bit_cnt_q == 5'd23) begin
                                    bit_cnt_q <= '0;
                                    dq0_q     <= 1'b0;
                                    state_q   <= ST_DATA;
                                end
                            end
                            default: begin
                                dq0_q <= 1'b0;
                                if (bit_cnt_q == 5'd7) begin
                                    bit_cnt_q <= '0;
                                    if (byte_cnt_q == BYTE_LAST) begin
                                        state_q <= ST_CSHOLD;
                                    end else begin
                                        byte_cnt_q <= byte_cnt_q + 8'd1;
                                    end
                                end
                            end
                        endcase
                    end
                end

                ST_CSHOLD: begin
                    // SCK has been low since the last falling edge. Keep CS low
                    // for one more half-period, then release it and start the
                    // UART frame with its start bit.
                    if (sck_div_q == SCK_LAST) begin
                        sck_div_q  <= '0;
                        cs_q       <= 1'b1;
                        tx_q       <= 1'b0;
                        uart_sr_q  <= {1'b1, sum_q};
                        uart_div_q <= '0;
                        uart_bit_q <= '0;
                        state_q    <= ST_UART;
                    end else begin
                        sck_div_q <= sck_div_q + 16'd1;
                    end
                end

                ST_UART: begin
                    if (uart_div_q == UART_LAST) begin
                        uart_div_q <= '0;
                        if (uart_bit_q == 4'd9) begin
                            tx_q      <= 1'b1;
                            success_q <= (sum_q == EXPECTED_SUM);
                            state_q   <= ST_DONE;
                        end else begin
                            tx_q       <= uart_sr_q[0];
                            uart_sr_q  <= {1'b1, uart_sr_q[8:1]};
                            uart_bit_q <= uart_bit_q + 4'd1;
                        end
                    end else begin
                        uart_div_q <= uart_div_q + 16'd1;
                    end
                end

                ST_DONE: begin
                    cs_q  <= 1'b1;
                    sck_q <= 1'b0;
                    tx_q  <= 1'b1;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign success     = success_q;
    assign uart_tx     = tx_q;
    assign qspi_cs     = cs_q;
    assign qspi_sck    = sck_q;
    assign qspi_dq_0   = dq0_q;
    assign qspi_dq_2   = 1'b1;
    assign qspi_dq_3   = 1'b1;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sau_mau_ping_core.sv
// -----------------------------------------------------------------------------
// tb_sau_mau_ping_core
//
// Directed checks on three DUT configurations:
//   u0  defaults (addr 0, 16 bytes, expected sum 00)
//   u1  BOOT_ADDR 123456, EXPECTED_SUM 88, with a reset in the middle of ADDR
//   u2  SCK_DIV 1, UART_DIV 4, 2 bytes
// Only one DUT is out of reset at a time. A mux selects that DUT's outputs, and
// a shared flash model serves it.
// -----------------------------------------------------------------------------
module tb_sau_mau_ping_core;

    localparam logic [2:0] ST_ADDR = 3'd2;
    localparam logic [2:0] ST_DONE = 3'd6;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    logic rst2 = 1'b1;
    logic uart_rx = 1'b1;
    logic miso;

    logic       succ0, tx0, cs0, sck0, d00, d20, d30;
    logic       succ1, tx1, cs1, sck1, d01, d21, d31;
    logic       succ2, tx2, cs2, sck2, d02, d22, d32;
    logic [2:0] st0, st1, st2;

    sau_mau_ping_core u0 (
        .clk(clk), .rstn(rst0), .success(succ0), .uart_tx(tx0), .uart_rx(uart_rx),
        .qspi_cs(cs0), .qspi_sck(sck0), .qspi_dq_0(d00), .qspi_dq_1(miso),
        .qspi_dq_2(d20), .qspi_dq_3(d30), .dbg_state_o(st0)
    );

    sau_mau_ping_core #(.BOOT_ADDR(24'h123456), .EXPECTED_SUM(8'h88)) u1 (
        .clk(clk), .rstn(rst1), .success(succ1), .uart_tx(tx1), .uart_rx(uart_rx),
        .qspi_cs(cs1), .qspi_sck(sck1), .qspi_dq_0(d01), .qspi_dq_1(miso),
        .qspi_dq_2(d21), .qspi_dq_3(d31), .dbg_state_o(st1)
    );

    sau_mau_ping_core #(.SCK_DIV(1), .UART_DIV(4), .BOOT_BYTES(2)) u2 (
        .clk(clk), .rstn(rst2), .success(succ2), .uart_tx(tx2), .uart_rx(uart_rx),
        .qspi_cs(cs2), .qspi_sck(sck2), .qspi_dq_0(d02), .qspi_dq_1(miso),
        .qspi_dq_2(d22), .qspi_dq_3(d32), .dbg_state_o(st2)
    );

    // ---------------- monitor mux ----------------
    int         sel = 0;
    logic       mon_cs, mon_sck, mon_dq0, mon_tx, mon_succ, mon_dq2, mon_dq3;
    logic [2:0] mon_state;

    always_comb begin
        mon_cs = cs0; mon_sck = sck0; mon_dq0 = d00; mon_tx = tx0;
        mon_succ = succ0; mon_dq2 = d20; mon_dq3 = d30; mon_state = st0;
        if (sel == 1) begin
            mon_cs = cs1; mon_sck = sck1; mon_dq0 = d01; mon_tx = tx1;
            mon_succ = succ1; mon_dq2 = d21; mon_dq3 = d31; mon_state = st1;
        end else if (sel == 2) begin
            mon_cs = cs2; mon_sck = sck2; mon_dq0 = d02; mon_tx = tx2;
            mon_succ = succ2; mon_dq2 = d22; mon_dq3 = d32; mon_state = st2;
        end
    end

    // ---------------- flash model ----------------
    int          pulse_cnt = 0;
    int          data_mode = 0;   // 0: all 00, 1: byte k = k+1
    logic [31:0] mosi_sr = '0;

    function automatic logic flash_bit(input int pc, input int mode);
        int         idx;
        logic [7:0] b;
        if (pc < 32) return 1'b0;
        idx = pc - 32;
        b = (mode == 1) ? 8'((idx / 8) + 1) : 8'h00;
        return b[7 - (idx % 8)];
    endfunction

    assign miso = flash_bit(pulse_cnt, data_mode);

    always @(negedge mon_cs) begin
        pulse_cnt = 0;
        mosi_sr   = '0;
    end

    always @(posedge mon_sck) begin
        if (mon_cs == 1'b0) begin
            if (pulse_cnt < 32) mosi_sr = {mosi_sr[30:0], mon_dq0};
            pulse_cnt = pulse_cnt + 1;
        end
    end

    // ---------------- scoreboard / check ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- transaction observer ----------------
    int         r_cs_low, r_sck_period, r_frame;
    logic [7:0] r_byte;
    logic       r_start, r_stop, r_timeout;

    task automatic run_txn(input int udiv);
        int   t;
        int   k;
        int   rise1;
        int   rise2;
        logic prev_sck;
        r_cs_low = 0; r_sck_period = 0; r_frame = 0; r_byte = '0;
        r_start = 1'b1; r_stop = 1'b0; r_timeout = 1'b0;
        rise1 = -1; rise2 = -1; prev_sck = 1'b0;
        t = 0;
        while (mon_cs !== 1'b0 && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) r_timeout = 1'b1;
        t = 0;
        while (mon_cs === 1'b0 && t < 5000) begin
            if (mon_sck && !prev_sck) begin
                if (rise1 < 0) rise1 = t;
                else if (rise2 < 0) rise2 = t;
            end
            prev_sck = mon_sck;
            r_cs_low++;
            @(negedge clk);
            t++;
        end
        if (t >= 5000) r_timeout = 1'b1;
        r_sck_period = rise2 - rise1;
        t = 0;
        while (mon_tx !== 1'b0 && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) r_timeout = 1'b1;
        k = 0;
        while (mon_state != ST_DONE && k < 20 * udiv) begin
            if (k % udiv == udiv / 2) begin
                if (k / udiv == 0) r_start = mon_tx;
                else if (k / udiv <= 8) r_byte[k / udiv - 1] = mon_tx;
                else if (k / udiv == 9) r_stop = mon_tx;
            end
            k++;
            @(negedge clk);
        end
        if (k >= 20 * udiv) r_timeout = 1'b1;
        r_frame = k;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t;

        // ---- u0 reset state ----
        sel = 0;
        repeat (3) @(negedge clk);
        check("rst_cs", 32'(mon_cs), 32'h1);
        check("rst_sck", 32'(mon_sck), 32'h0);
        check("rst_dq0", 32'(mon_dq0), 32'h0);
        check("rst_tx", 32'(mon_tx), 32'h1);
        check("rst_succ", 32'(mon_succ), 32'h0);
        check("rst_dq2", 32'(mon_dq2), 32'h1);
        check("rst_dq3", 32'(mon_dq3), 32'h1);
        check("rst_state", 32'(mon_state), 32'h0);

        // ---- u0: 16 zero bytes, defaults ----
        data_mode = 0;
        rst0 = 1'b0;
        run_txn(16);
        check("t1_timeout", 32'(r_timeout), 32'h0);
        check("t1_pulses", 32'(pulse_cnt), 32'd160);
        check("t1_cs_low", 32'(r_cs_low), 32'd642);
        check("t1_sck_per", 32'(r_sck_period), 32'd4);
        check("t1_mosi", mosi_sr, 32'h03000000);
        check("t1_start", 32'(r_start), 32'h0);
        check("t1_byte", 32'(r_byte), 32'h00);
        check("t1_stop", 32'(r_stop), 32'h1);
        check("t1_frame", 32'(r_frame), 32'd160);
        check("t1_state", 32'(mon_state), 32'(ST_DONE));
        check("t1_succ", 32'(mon_succ), 32'h1);
        repeat (20) @(negedge clk);
        check("t1_done_cs", 32'(mon_cs), 32'h1);
        check("t1_done_sck", 32'(mon_sck), 32'h0);
        check("t1_done_tx", 32'(mon_tx), 32'h1);
        check("t1_succ_hold", 32'(mon_succ), 32'h1);

        // ---- u0: bytes 01..10, expected 00 -> mismatch ----
        rst0 = 1'b1;
        repeat (2) @(negedge clk);
        check("t2_rst_succ", 32'(mon_succ), 32'h0);
        data_mode = 1;
        rst0 = 1'b0;
        run_txn(16);
        check("t2_timeout", 32'(r_timeout), 32'h0);
        check("t2_byte", 32'(r_byte), 32'h88);
        check("t2_succ", 32'(mon_succ), 32'h0);
        repeat (200) @(negedge clk);
        check("t2_succ_late", 32'(mon_succ), 32'h0);
        rst0 = 1'b1;

        // ---- u1: addr 123456, reset during ADDR, then full run ----
        sel = 1;
        data_mode = 1;
        @(negedge clk);
        rst1 = 1'b0;
        t = 0;
        while (mon_state != ST_ADDR && t < 200) begin @(negedge clk); t++; end
        check("t3_reach_addr", 32'(t < 200), 32'h1);
        repeat (10) @(negedge clk);
        check("t3_cs_low_mid", 32'(mon_cs), 32'h0);
        #2 rst1 = 1'b1;
        #1;
        check("t3_cs_abort", 32'(mon_cs), 32'h1);
        check("t3_sck_abort", 32'(mon_sck), 32'h0);
        repeat (3) @(negedge clk);
        check("t3_state_rst", 32'(mon_state), 32'h0);
        rst1 = 1'b0;
        run_txn(16);
        check("t3_timeout", 32'(r_timeout), 32'h0);
        check("t3_mosi", mosi_sr, 32'h03123456);
        check("t3_pulses", 32'(pulse_cnt), 32'd160);
        check("t3_byte", 32'(r_byte), 32'h88);
        check("t3_stop", 32'(r_stop), 32'h1);
        check("t3_succ", 32'(mon_succ), 32'h1);
        rst1 = 1'b1;

        // ---- u2: SCK_DIV 1, UART_DIV 4, 2 zero bytes ----
        sel = 2;
        data_mode = 0;
        repeat (2) @(negedge clk);
        check("t4_rst_cs", 32'(mon_cs), 32'h1);
        check("t4_rst_tx", 32'(mon_tx), 32'h1);
        rst2 = 1'b0;
        run_txn(4);
        check("t4_timeout", 32'(r_timeout), 32'h0);
        check("t4_sck_per", 32'(r_sck_period), 32'd2);
        check("t4_pulses", 32'(pulse_cnt), 32'd48);
        check("t4_cs_low", 32'(r_cs_low), 32'd97);
        check("t4_frame", 32'(r_frame), 32'd40);
        check("t4_start", 32'(r_start), 32'h0);
        check("t4_stop", 32'(r_stop), 32'h1);
        check("t4_byte", 32'(r_byte), 32'h00);
        check("t4_succ", 32'(mon_succ), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
